// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store, LATENCY wait states,
// byte-lane stores and raw aligned-word loads with misalignment reporting.
module data_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [1:0]            req_size,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  stall
);

  localparam int IDX_W = DM_ADDRESS - 2;
  localparam int WORDS = 2 ** IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [DATA_W-1:0]     r_resp_rdata;
  logic                  r_resp_err;
  logic                  r_write;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [1:0]            r_size;
  logic [DATA_W-1:0]     r_mem [WORDS];

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   return 1'b0;
      2'b10:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   return 4'b0001 << a;
      2'b10:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate lane-0 justified store data so every enabled lane sees its byte.
  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] size,
                                                  input logic [DATA_W-1:0] d);
    case (size)
      2'b01:   return {4{d[7:0]}};
      2'b10:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // The request being committed comes straight from the ports when LATENCY==1.
  logic                  w_sel_in;
  logic                  w_write;
  logic [DM_ADDRESS-1:0] w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic [1:0]            w_size;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_err;
  logic [3:0]            w_be;
  logic [DATA_W-1:0]     w_lanes;
  logic                  w_accept;
  logic                  w_enter_resp;

  assign w_sel_in     = (r_state == S_IDLE);
  assign w_write      = w_sel_in ? req_write : r_write;
  assign w_addr       = w_sel_in ? req_addr  : r_addr;
  assign w_wdata      = w_sel_in ? req_wdata : r_wdata;
  assign w_size       = w_sel_in ? req_size  : r_size;
  assign w_idx        = w_addr[DM_ADDRESS-1:2];
  assign w_err        = misaligned(w_size, w_addr[1:0]);
  assign w_be         = byte_en(w_size, w_addr[1:0]);
  assign w_lanes      = lane_data(w_size, w_wdata);
  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_enter_resp = (w_accept && (LATENCY == 1)) || ((r_state == S_WAIT) && (r_cnt == 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_size      <= req_size;
            r_cnt       <= 4'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
      endcase
      if (w_enter_resp) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (!w_write && !w_err) ? r_mem[w_idx] : '0;
      end
    end
  end

  // Storage is never reset; a reset while waiting suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && w_enter_resp && w_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_lanes[8*i +: 8];
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign stall      = req_valid & ~r_resp_valid;

endmodule
